fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Pipeline forwarding and load-use hazard controller for the 5-stage processor. It tracks destination-register information for the instructions in EX, MEM and WB. It produces registered 2-bit select codes for the two EX-stage operand 3-input multiplexers (ALU A and ALU B). It also detects load-use hazards, requests a one-cycle stall and inserts a bubble into EX. It sits between the ID stage decode outputs and the EX-stage operand muxes.

## Interface
Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the stall-bubble counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- pipe_en  in  1  global advance enable; 0 freezes all internal state and registered outputs.
- flush  in  1  taken-branch flush; discards the instruction currently in ID.
- id_rs  in  REG_AW  source register A of the ID instruction.
- id_rt  in  REG_AW  source register B of the ID instruction.
- id_uses_rt  in  1  ID instruction reads rt as an operand.
- id_rd  in  REG_AW  destination register of the ID instruction.
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- fwd_a_sel  out  2  operand A mux select for the EX instruction.
- fwd_b_sel  out  2  operand B mux select for the EX instruction.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- bubble_cnt  out  CNT_W  saturating count of stall bubbles inserted.

## Operation
- Select encoding:
  - 2'b00: register-file value.
  - 2'b01: MEM/WB result.
  - 2'b10: EX/MEM ALU result.
  - 2'b11: never driven.
- Internal slots:
  - EX slot: {rd, reg_write, mem_read}.
  - MEM slot: {rd, reg_write, mem_read}.
  - WB slot: {rd, reg_write}.
- Hazard condition: EX.mem_read & EX.rd≠0 & (EX.rd==id_rs | (id_uses_rt & EX.rd==id_rt)).
- stall = hazard & ~flush & pipe_en.
- On each edge with pipe_en=1:
  - WB ← MEM, MEM ← EX.
  - EX ← ID fields, or a bubble (all fields 0) when stall or flush is active.
- Forwarding selects are computed from ID-stage values. They are registered into fwd_*_sel on the same edge the ID instruction enters EX.
  - 10 if EX.rd==src, EX.reg_write=1, EX.rd≠0.
  - Else 01 if MEM.rd==src, MEM.reg_write=1, MEM.rd≠0.
  - Else 00.
  - The newer producer (EX/MEM) has priority over MEM/WB.
- fwd_b_sel uses id_rt and is forced to 00 when id_uses_rt=0.
- On a bubble entry (stall or flush), both selects are registered as 00.
- Register 0 is never forwarded.
- The register file writes in the first half-cycle, so a WB-stage write read by ID in the same cycle is not forwarded.
- bubble_cnt increments by 1 on every edge where stall=1, and saturates at 2^CNT_W−1. flush bubbles are not counted.

## Timing
- Reset (rst_n=0 at an edge):
  - All slots cleared to 0.
  - fwd_a_sel=fwd_b_sel=00, bubble_cnt=0.
  - stall therefore 0 in the next cycle.
- Reset overrides pipe_en and flush.
- Select latency: one edge. A select computed in cycle n is valid throughout cycle n+1, while the instruction is in EX.
- Load-use sequence:
  - Cycle n: load in EX, dependent instruction in ID, stall=1.
  - Edge n: bubble into EX, load into MEM.
  - Cycle n+1: stall=0, load not in EX.
  - Edge n+1: dependent instruction enters EX with select 01 (load now in WB).
- flush and hazard in the same cycle: flush wins, stall=0, bubble inserted.
- pipe_en=0: stall forced to 0. Slots, selects and bubble_cnt hold.
- pipe_en=0 has no effect on reset.

## Structure
- Shared package fwd_pkg holds:
  - REG_AW.
  - Select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Slot struct typedef {rd, reg_write, mem_read}.
- Sub-module fwd_sel_cmp: inputs src, uses, EX slot and MEM slot; output a 2-bit select. It is combinational and instantiated twice (A and B).
- The slot registers, hazard logic and counter stay in the top module.

## Test plan
- Reset: hold rst_n=0 with random ID inputs for 3 edges, then release. Required: sel=00/00, stall=0, bubble_cnt=0.
- EX/MEM forward: ADD r3 then SUB r5,r3,r3 back-to-back. Required: fwd_a_sel=10 and fwd_b_sel=10 in SUB's EX cycle.
- Priority and r0:
  - ADD r4, ADD r4, then OR r6,r4,r0 (uses_rt=1). Required: fwd_a_sel=10, fwd_b_sel=00.
  - Separately, producer writes r0. Required: sel=00.
- Load-use: LW r2, then ADD r7,r2,r1.
  - Required: stall=1 for exactly one cycle, bubble_cnt=1.
  - ADD enters EX with fwd_a_sel=01, fwd_b_sel=00.
- Flush with hazard: load in EX, dependent instruction in ID, flush=1. Required: stall=0, bubble inserted, bubble_cnt unchanged, next selects 00.
- Freeze and saturate:
  - pipe_en=0 during a hazard. Required: stall=0, all outputs held.
  - With CNT_W=2, 5 load-use stalls. Required: bubble_cnt=3.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage forwarding and load-use hazard logic.
package fwd_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } fwd_slot_t;

  // True when the slot holds an instruction that will write a forwardable value to src.
  function automatic logic slot_writes(input fwd_slot_t s, input logic [REG_AW-1:0] src);
    return s.reg_write && (s.rd != '0) && (s.rd == src);
  endfunction

endpackage

// File: rtl/fwd_sel_cmp.sv
// Operand forwarding select for one EX-stage source; the newer producer (EX/MEM) wins.
module fwd_sel_cmp
  import fwd_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              uses,
  input  fwd_slot_t         ex_slot,
  input  fwd_slot_t         mem_slot,
  output logic [1:0]        sel
);

  // Load status only matters to the hazard detector, not to select generation.
  logic unused_mem_read;
  assign unused_mem_read = ex_slot.mem_read ^ mem_slot.mem_read;

  always_comb begin
    sel = FWD_RF;
    if (uses) begin
      if (slot_writes(ex_slot, src)) begin
        sel = FWD_MEM;
      end else if (slot_writes(mem_slot, src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks producers in EX/MEM, registers operand-forwarding selects for EX and
// stalls one cycle on a load-use dependency.
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_en,
  input  logic              flush,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  import fwd_pkg::fwd_slot_t;
  import fwd_pkg::FWD_RF;

  // WB-stage producers are covered by the register file's write-first behaviour,
  // so only the EX and MEM slots are kept.
  fwd_slot_t        ex_slot_reg;
  fwd_slot_t        mem_slot_reg;
  fwd_slot_t        id_slot;
  logic [1:0]       fwd_a_sel_reg;
  logic [1:0]       fwd_b_sel_reg;
  logic [1:0]       sel_a_next;
  logic [1:0]       sel_b_next;
  logic [CNT_W-1:0] bubble_cnt_reg;
  logic             hazard;
  logic             bubble;

  assign id_slot = fwd_slot_t'{rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

  assign hazard = ex_slot_reg.mem_read && (ex_slot_reg.rd != '0) &&
                  ((ex_slot_reg.rd == id_rs) || (id_uses_rt && (ex_slot_reg.rd == id_rt)));

  assign stall  = hazard && !flush && pipe_en;
  assign bubble = stall || flush;

  fwd_sel_cmp u_sel_a (
    .src      (id_rs),
    .uses     (1'b1),
    .ex_slot  (ex_slot_reg),
    .mem_slot (mem_slot_reg),
    .sel      (sel_a_next)
  );

  fwd_sel_cmp u_sel_b (
    .src      (id_rt),
    .uses     (id_uses_rt),
    .ex_slot  (ex_slot_reg),
    .mem_slot (mem_slot_reg),
    .sel      (sel_b_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_slot_reg    <= '0;
      mem_slot_reg   <= '0;
      fwd_a_sel_reg  <= FWD_RF;
      fwd_b_sel_reg  <= FWD_RF;
      bubble_cnt_reg <= '0;
    end else if (pipe_en) begin
      mem_slot_reg <= ex_slot_reg;
      if (bubble) begin
        ex_slot_reg   <= '0;
        fwd_a_sel_reg <= FWD_RF;
        fwd_b_sel_reg <= FWD_RF;
      end else begin
        ex_slot_reg   <= id_slot;
        fwd_a_sel_reg <= sel_a_next;
        fwd_b_sel_reg <= sel_b_next;
      end
      if (stall && (bubble_cnt_reg != {CNT_W{1'b1}})) begin
        bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
      end
    end
  end

  assign fwd_a_sel  = fwd_a_sel_reg;
  assign fwd_b_sel  = fwd_b_sel_reg;
  assign bubble_cnt = bubble_cnt_reg;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized and directed bench for fwd_hazard_unit against an in-flight instruction model.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_en;
  logic        flush;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt, id_reg_write, id_mem_read;
  logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_a_sel2, fwd_b_sel2;
  logic        stall, stall2;
  logic [15:0] bubble_cnt;
  logic [1:0]  bubble_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall), .bubble_cnt(bubble_cnt)
  );

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .fwd_a_sel(fwd_a_sel2), .fwd_b_sel(fwd_b_sel2), .stall(stall2), .bubble_cnt(bubble_cnt2)
  );

  // Model: the two in-flight instructions after ID, index 0 = youngest (in EX).
  typedef struct {
    int rd;
    bit wr;
    bit ld;
  } instr_t;

  instr_t inflight[2];
  int     m_sel_a, m_sel_b, m_cnt, m_cnt_sat;
  int     obs_a, obs_b, obs_stall, obs_cnt, obs_cnt_sat;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Distance-based forwarding: the nearest older writer of src supplies the value.
  function automatic int model_src(input int src, input bit used);
    if (!used || src == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (inflight[k].wr && inflight[k].rd == src) return (k == 0) ? 2 : 1;
    return 0;
  endfunction

  function automatic bit model_hazard(input int rs, input int rt, input bit ut);
    return inflight[0].ld && inflight[0].rd != 0 &&
           (inflight[0].rd == rs || (ut && inflight[0].rd == rt));
  endfunction

  task automatic model_reset();
    inflight[0] = '{0, 0, 0};
    inflight[1] = '{0, 0, 0};
    m_sel_a = 0; m_sel_b = 0; m_cnt = 0; m_cnt_sat = 0;
  endtask

  // One pipeline cycle: drive ID, check all outputs against the model, then clock.
  task automatic cycle(input int rs, input int rt, input bit ut, input int rd,
                       input bit rw, input bit mr, input bit fl, input bit en, input bit rst);
    bit exp_stall;
    bit bub;
    @(negedge clk);
    id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = ut; id_rd = 5'(rd);
    id_reg_write = rw; id_mem_read = mr; flush = fl; pipe_en = en; rst_n = !rst;
    #1;
    exp_stall = model_hazard(rs, rt, ut) && !fl && en;
    obs_a = fwd_a_sel; obs_b = fwd_b_sel; obs_stall = stall;
    obs_cnt = bubble_cnt; obs_cnt_sat = bubble_cnt2;
    check_val("stall", stall, exp_stall);
    check_val("stall_sat", stall2, exp_stall);
    check_val("fwd_a_sel", fwd_a_sel, m_sel_a);
    check_val("fwd_b_sel", fwd_b_sel, m_sel_b);
    check_val("bubble_cnt", bubble_cnt, m_cnt);
    check_val("bubble_cnt_sat", bubble_cnt2, m_cnt_sat);
    $display("cyc t=%0t rst=%0b en=%0b fl=%0b rs=%0d rt=%0d ut=%0b rd=%0d rw=%0b mr=%0b | a=%0d b=%0d st=%0b cnt=%0d",
             $time, rst, en, fl, rs, rt, ut, rd, rw, mr, fwd_a_sel, fwd_b_sel, stall, bubble_cnt);
    if (rst) begin
      model_reset();
    end else if (en) begin
      bub = exp_stall || fl;
      m_sel_a = bub ? 0 : model_src(rs, 1'b1);
      m_sel_b = bub ? 0 : model_src(rt, ut);
      inflight[1] = inflight[0];
      inflight[0] = bub ? '{0, 0, 0} : '{rd, rw, mr};
      if (exp_stall) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_sat < 3) m_cnt_sat++;
      end
    end
    @(posedge clk);
  endtask

  task automatic nop();
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    int base;
    model_reset();
    // Reset with random ID activity for three edges
    for (int i = 0; i < 3; i++)
      cycle($urandom_range(31), $urandom_range(31), 1'($urandom), $urandom_range(31),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
    nop();
    check_val("rst_a", obs_a, 0);
    check_val("rst_b", obs_b, 0);
    check_val("rst_stall", obs_stall, 0);
    check_val("rst_cnt", obs_cnt, 0);

    // ADD r3 ; SUB r5,r3,r3
    cycle(1, 2, 1, 3, 1, 0, 0, 1, 0);
    cycle(3, 3, 1, 5, 1, 0, 0, 1, 0);
    nop();
    check_val("exmem_a", obs_a, 2);
    check_val("exmem_b", obs_b, 2);

    // ADD r4 ; ADD r4 ; OR r6,r4,r0
    cycle(1, 2, 1, 4, 1, 0, 0, 1, 0);
    cycle(1, 2, 1, 4, 1, 0, 0, 1, 0);
    cycle(4, 0, 1, 6, 1, 0, 0, 1, 0);
    nop();
    check_val("prio_a", obs_a, 2);
    check_val("r0_b", obs_b, 0);
    // Producer writes r0
    cycle(1, 2, 1, 0, 1, 0, 0, 1, 0);
    cycle(0, 0, 1, 7, 1, 0, 0, 1, 0);
    nop();
    check_val("r0prod_a", obs_a, 0);
    check_val("r0prod_b", obs_b, 0);

    // LW r2 ; ADD r7,r2,r1
    base = m_cnt;
    cycle(9, 0, 0, 2, 1, 1, 0, 1, 0);
    cycle(2, 1, 1, 7, 1, 0, 0, 1, 0);
    check_val("lu_stall1", obs_stall, 1);
    cycle(2, 1, 1, 7, 1, 0, 0, 1, 0);
    check_val("lu_stall2", obs_stall, 0);
    nop();
    check_val("lu_a", obs_a, 1);
    check_val("lu_b", obs_b, 0);
    check_val("lu_cnt", obs_cnt, base + 1);

    // Flush while a load-use hazard is present
    base = m_cnt;
    cycle(9, 0, 0, 2, 1, 1, 0, 1, 0);
    cycle(2, 1, 1, 7, 1, 0, 1, 1, 0);
    check_val("fl_stall", obs_stall, 0);
    nop();
    check_val("fl_a", obs_a, 0);
    check_val("fl_b", obs_b, 0);
    check_val("fl_cnt", obs_cnt, base);

    // Freeze during a hazard
    base = m_cnt;
    cycle(9, 0, 0, 2, 1, 1, 0, 1, 0);
    cycle(2, 1, 1, 7, 1, 0, 0, 0, 0);
    check_val("frz_stall", obs_stall, 0);
    cycle(2, 1, 1, 7, 1, 0, 0, 0, 0);
    check_val("frz_cnt", obs_cnt, base);
    cycle(2, 1, 1, 7, 1, 0, 0, 1, 0);
    check_val("frz_resume_stall", obs_stall, 1);

    // Five load-use stalls saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      cycle(9, 0, 0, 2, 1, 1, 0, 1, 0);
      cycle(2, 1, 1, 7, 1, 0, 0, 1, 0);
      cycle(2, 1, 1, 7, 1, 0, 0, 1, 0);
    end
    nop();
    check_val("sat_cnt", obs_cnt_sat, 3);

    // Random traffic over a small register set to provoke dependencies
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(7), $urandom_range(7), 1'($urandom), $urandom_range(7),
            ($urandom_range(3) != 0), ($urandom_range(2) == 0), ($urandom_range(9) == 0),
            ($urandom_range(7) != 0), ($urandom_range(199) == 0));
    end
    nop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
